// File: rtl/otbn_rf_base_wipe_seq_if.sv
// Base GPR file port bundle driven by the secure-wipe sequencer.
// Holds the urnd request/ack pair and the RF write and read-A ports.
//
// Signals (master = sequencer side):
//   urnd_req_o         out  request a random word
//   urnd_ack_i         in   urnd_data_i valid this cycle
//   urnd_data_i        in   32-bit random word
//   wr_addr_o          out  GPR write address
//   wr_en_o            out  write intent
//   wr_commit_o        out  write commit
//   wr_data_no_intg_o  out  32-bit data, RF adds integrity
//   wr_data_intg_o     out  39-bit data with integrity
//   wr_data_intg_sel_o out  1: RF takes wr_data_intg_o
//   rd_addr_a_o        out  read port A address
//   rd_en_a_o          out  read intent
//   rd_commit_o        out  read commit
//   rd_data_a_intg_i   in   39-bit read data, combinational
//   intg_err_i         in   RF integrity error
interface otbn_rf_base_wipe_seq_if;

  logic        urnd_req_o;
  logic        urnd_ack_i;
  logic [31:0] urnd_data_i;

  logic [4:0]  wr_addr_o;
  logic        wr_en_o;
  logic        wr_commit_o;
  logic [31:0] wr_data_no_intg_o;
  logic [38:0] wr_data_intg_o;
  logic        wr_data_intg_sel_o;

  logic [4:0]  rd_addr_a_o;
  logic        rd_en_a_o;
  logic        rd_commit_o;
  logic [38:0] rd_data_a_intg_i;
  logic        intg_err_i;

  modport master (
    output urnd_req_o,
    input  urnd_ack_i,
    input  urnd_data_i,
    output wr_addr_o,
    output wr_en_o,
    output wr_commit_o,
    output wr_data_no_intg_o,
    output wr_data_intg_o,
    output wr_data_intg_sel_o,
    output rd_addr_a_o,
    output rd_en_a_o,
    output rd_commit_o,
    input  rd_data_a_intg_i,
    input  intg_err_i
  );

  modport slave (
    input  urnd_req_o,
    output urnd_ack_i,
    output urnd_data_i,
    input  wr_addr_o,
    input  wr_en_o,
    input  wr_commit_o,
    input  wr_data_no_intg_o,
    input  wr_data_intg_o,
    input  wr_data_intg_sel_o,
    input  rd_addr_a_o,
    input  rd_en_a_o,
    input  rd_commit_o,
    output rd_data_a_intg_i,
    output intg_err_i
  );

endinterface

// File: rtl/otbn_rf_base_wipe_seq.sv
// Secure-wipe sequencer for the OTBN base GPR file.
// Passes: random fill, inverted-SECDED zero fill, call-stack
// clear, optional read-back verify of x[FirstReg..LastReg].
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   start_i        begin wipe (IDLE only)
//   abort_i        abandon wipe, IDLE next cycle
//   rf             RF/urnd port bundle (master)
//   stack_reset_o  one-cycle call-stack clear
//   busy_o         sequence in progress
//   done_o         one-cycle completion pulse
//   err_o          sticky verify failure
module otbn_rf_base_wipe_seq #(
  parameter int unsigned FirstReg = 2,
  parameter int unsigned LastReg  = 31,
  parameter bit          VerifyEn = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic abort_i,
  otbn_rf_base_wipe_seq_if.master rf,
  output logic stack_reset_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  // Encoded zero word of the inverted 39/32 SECDED code.
  localparam logic [38:0] ZeroWord =
    39'h2A00000000;

  localparam logic [4:0] FirstAddr =
    FirstReg[4:0];
  localparam logic [4:0] LastAddr =
    LastReg[4:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_RND,
    S_ZERO,
    S_STACK,
    S_VERIFY,
    S_DONE
  } state_e;

  state_e     r_state;
  logic [4:0] r_cnt;
  logic       r_err;

  logic w_kill;
  logic w_last;
  logic w_in_rnd;
  logic w_wr_rnd;
  logic w_wr_zero;
  logic w_rd;
  logic w_bad;
  logic w_busy_st;

  // Abort and reset both suppress any RF or stack
  // side effect in the cycle they are seen.
  assign w_kill = rst_i | abort_i;
  assign w_last = (r_cnt == LastAddr);

  assign w_in_rnd  = (r_state == S_RND) & ~w_kill;
  assign w_wr_rnd  = w_in_rnd & rf.urnd_ack_i;
  assign w_wr_zero = (r_state == S_ZERO) & ~w_kill;
  assign w_rd      = (r_state == S_VERIFY) & ~w_kill;

  assign w_bad = w_rd &
    ((rf.rd_data_a_intg_i != ZeroWord) |
     rf.intg_err_i);

  assign w_busy_st =
    (r_state == S_RND)   |
    (r_state == S_ZERO)  |
    (r_state == S_STACK) |
    (r_state == S_VERIFY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= FirstAddr;
      r_err   <= 1'b0;
    end else if (abort_i &&
                 r_state != S_IDLE) begin
      r_state <= S_IDLE;
      r_cnt   <= FirstAddr;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_RND;
            r_cnt   <= FirstAddr;
            r_err   <= 1'b0;
          end
        end
        S_RND: begin
          // Only an acked word is written; the
          // counter holds while urnd stalls.
          if (rf.urnd_ack_i) begin
            if (w_last) begin
              r_state <= S_ZERO;
              r_cnt   <= FirstAddr;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_ZERO: begin
          if (w_last) begin
            r_state <= S_STACK;
            r_cnt   <= FirstAddr;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_STACK: begin
          r_cnt   <= FirstAddr;
          r_state <= VerifyEn ? S_VERIFY
                              : S_DONE;
        end
        S_VERIFY: begin
          if (w_bad) begin
            r_err <= 1'b1;
          end
          if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= FirstAddr;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= FirstAddr;
        end
      endcase
    end
  end

  // RF port drive; every field idles at zero
  // whenever its enable is low.
  always_comb begin
    rf.wr_addr_o          = 5'd0;
    rf.wr_en_o            = 1'b0;
    rf.wr_commit_o        = 1'b0;
    rf.wr_data_no_intg_o  = 32'd0;
    rf.wr_data_intg_o     = 39'd0;
    rf.wr_data_intg_sel_o = 1'b0;
    rf.rd_addr_a_o        = 5'd0;
    rf.rd_en_a_o          = 1'b0;
    rf.rd_commit_o        = 1'b0;
    unique case (1'b1)
      w_wr_rnd: begin
        rf.wr_addr_o         = r_cnt;
        rf.wr_en_o           = 1'b1;
        rf.wr_commit_o       = 1'b1;
        rf.wr_data_no_intg_o =
          rf.urnd_data_i;
      end
      w_wr_zero: begin
        rf.wr_addr_o          = r_cnt;
        rf.wr_en_o            = 1'b1;
        rf.wr_commit_o        = 1'b1;
        rf.wr_data_intg_o     = ZeroWord;
        rf.wr_data_intg_sel_o = 1'b1;
      end
      w_rd: begin
        rf.rd_addr_a_o = r_cnt;
        rf.rd_en_a_o   = 1'b1;
        rf.rd_commit_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign rf.urnd_req_o = w_in_rnd;

  assign stack_reset_o =
    (r_state == S_STACK) & ~w_kill;
  assign done_o =
    (r_state == S_DONE) & ~w_kill;
  assign busy_o = w_busy_st & ~rst_i;
  assign err_o  = r_err;

endmodule
